riscv_seq_ctrl: RTL and testbench
=================================

# riscv_seq_ctrl

Multi-cycle sequencer for the RISC-V core datapath. It generates one-cycle go pulses to fetch, decode, register-read, ALU and writeback in order, waits for each stage's done, and then issues a PC-advance pulse. It supports free-running and single-step execution, halts cleanly at instruction boundaries, and counts retired instructions. It sits between the core's enable/debug inputs and the instruction-memory / PC / decode / register / ALU blocks.

## Interface
- TO_CYCLES, 16: stage watchdog limit in cycles (timeout build only); legal 2..255
- CNT_WIDTH, 32: width of retired-instruction counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  level; continuous execution while high
- step  in  1  single-step request; 1->0 edge starts one instruction
- halt  in  1  request stop at next instruction boundary
- fetch_go / fetch_done  out / in  1  fetch stage pulse / completion
- dec_go / dec_done  out / in  1  decode
- rf_go / rf_done  out / in  1  register read
- alu_go / alu_done  out / in  1  execute
- wb_go / wb_done  out / in  1  writeback
- branch_taken  in  1  sampled with alu_done
- pc_go  out  1  one-cycle PC advance pulse
- pc_sel_branch  out  1  PC source select, valid while pc_go=1
- busy  out  1  high in any state except IDLE
- state  out  3  current state encoding
- retired  out  CNT_WIDTH  retired-instruction count
- clr_err  in  1  clears ERR (timeout build only)
- timeout_err  out  1  sticky watchdog error

## Operation
- States: IDLE=0, FETCH=1, DEC=2, RF=3, EXE=4, WB=5, RET=6, ERR=7.
- Step edge: a registered step_d is kept; step_pulse = ~step & step_d.
- IDLE -> FETCH when run=1 or step_pulse=1. Both asserted together start exactly one entry.
- Each stage state asserts its go signal only in the first cycle after entry.
- done is ignored in that entry cycle. The first done=1 on a later cycle advances the state: FETCH->DEC->RF->EXE->WB->RET.
- In EXE, branch_taken is latched on the alu_done cycle and held into RET as pc_sel_branch.
- RET lasts exactly one cycle:
  - pc_go=1 and pc_sel_branch=latched value
  - retired increments, wrapping modulo 2^CNT_WIDTH
  - next state is FETCH if run=1 and no halt is pending; otherwise IDLE
- halt=1 in any non-IDLE state sets halt_pend. halt_pend is cleared on leaving RET.
- halt in IDLE has no effect.
- step_pulse while busy=1 is ignored and not queued.
- Done inputs arriving in a state other than their own stage are ignored.
- rst_n low at any time: state=IDLE, all go pulses, pc_go, pc_sel_branch, busy, retired, timeout_err, halt_pend and step_d = 0. The instruction in flight is abandoned.

## Timing
- Stage entered at cycle t: go=1 at t. With done first seen at t+k (k>=1), the next state is entered at t+k+1.
- Done asserted at t+1 everywhere gives 2 cycles per stage and 11 cycles per instruction: 5 stages x 2 plus RET.
- The next fetch_go follows pc_go by exactly 1 cycle in run mode.
- From IDLE, fetch_go occurs 1 cycle after run rises or after step_pulse.
- step_pulse itself lags the step falling edge by 1 cycle.
- All outputs are registered. state, busy and the go pulses are glitch-free.

## Configuration
- RISCV_SEQ_TIMEOUT_EN defined:
  - An 8-bit watchdog resets on each stage entry and counts cycles without done.
  - When it reaches TO_CYCLES (done absent for cycles t+1..t+TO_CYCLES), the next state is ERR and timeout_err=1.
  - ERR holds with no go pulses and busy=1 until clr_err=1, which returns to IDLE and clears timeout_err 1 cycle later.
  - Done and timeout in the same cycle: done wins.
- Not defined: stages wait indefinitely, timeout_err is tied 0, clr_err is unused and ERR is unreachable.

## Test plan
- Step, zero-wait: step 1->0 with all done responding at t+1 -> go pulses at cycles 2,4,6,8,10 after the edge, pc_go at 12, retired=1, back to IDLE, busy=0.
- Run with branch: run=1 for 3 instructions, branch_taken=1 on the 2nd -> 3 pc_go pulses 11 cycles apart, pc_sel_branch=1 only on the 2nd, retired=3.
- Halt mid-instruction: halt pulsed during EXE while run=1 -> current instruction retires (pc_go=1), then IDLE with no further fetch_go.
- Wait states and stray inputs: dec_done delayed 5 cycles, plus a stray alu_done during FETCH -> decode state held 6 cycles, stray done ignored, order intact. step pulses while busy produce no extra instruction.
- Async reset: rst_n low during WB with retired=7 -> immediate IDLE, retired=0, all outputs 0. Restart on run works.
- Timeout (macro on, TO_CYCLES=4): rf_done never asserted -> ERR entered 5 cycles after rf_go, timeout_err=1. clr_err -> IDLE, timeout_err=0.

Source files
------------

// File: rtl/riscv_seq_ctrl_if.sv
// riscv_seq_ctrl_if: stage go/done handshakes and PC advance bundle
// between the sequencer (master) and the datapath blocks (slave).
interface riscv_seq_ctrl_if;
  logic fetch_go;
  logic fetch_done;
  logic dec_go;
  logic dec_done;
  logic rf_go;
  logic rf_done;
  logic alu_go;
  logic alu_done;
  logic wb_go;
  logic wb_done;
  logic branch_taken;
  logic pc_go;
  logic pc_sel_branch;

  modport master (
    output fetch_go, dec_go, rf_go,
    output alu_go, wb_go,
    output pc_go, pc_sel_branch,
    input  fetch_done, dec_done, rf_done,
    input  alu_done, wb_done, branch_taken
  );

  modport slave (
    input  fetch_go, dec_go, rf_go,
    input  alu_go, wb_go,
    input  pc_go, pc_sel_branch,
    output fetch_done, dec_done, rf_done,
    output alu_done, wb_done, branch_taken
  );
endinterface

// File: rtl/riscv_seq_ctrl.sv
// riscv_seq_ctrl: multi-cycle fetch/dec/rf/alu/wb sequencer.
// Stage watchdog and ERR state built only with RISCV_SEQ_TIMEOUT_EN.
module riscv_seq_ctrl #(
  parameter int TO_CYCLES = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 step,
  input  logic                 halt,
  input  logic                 clr_err,
  riscv_seq_ctrl_if.master     dp,
  output logic                 busy,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DEC   = 3'd2,
    RF    = 3'd3,
    EXE   = 3'd4,
    WB    = 3'd5,
    RET   = 3'd6,
    ERR   = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic [4:0]           go_q;
  logic                 entry_q;
  logic                 step_q;
  logic                 step_pulse_q;
  logic                 halt_pend_q;
  logic                 br_q;
  logic                 pc_go_q;
  logic                 pc_br_q;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] retired_q;

  logic in_stage;
  logic enter_stage;
  logic cur_done;
  logic wd_hit;
  logic clr_ok;

  assign in_stage = state_q inside
    {FETCH, DEC, RF, EXE, WB};
  assign enter_stage = (state_d != state_q) &&
    (state_d inside {FETCH, DEC, RF, EXE, WB});

  // done of the stage currently owning the sequencer
  always_comb begin
    cur_done = 1'b0;
    unique case (state_q)
      FETCH:   cur_done = dp.fetch_done;
      DEC:     cur_done = dp.dec_done;
      RF:      cur_done = dp.rf_done;
      EXE:     cur_done = dp.alu_done;
      WB:      cur_done = dp.wb_done;
      default: cur_done = 1'b0;
    endcase
  end

`ifdef RISCV_SEQ_TIMEOUT_EN
  logic [7:0] wd_q;
  logic       err_q;

  assign wd_hit = (wd_q == 8'(TO_CYCLES - 1));
  assign clr_ok = clr_err;
  assign timeout_err = err_q;

  // watchdog restarts on stage entry, counts done-less cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (enter_stage)
        wd_q <= '0;
      else if (in_stage && !entry_q && !cur_done)
        wd_q <= wd_q + 8'd1;
      err_q <= (state_d == ERR);
    end
  end
`else
  logic unused_clr;

  assign unused_clr = clr_err | (TO_CYCLES < 0);
  assign wd_hit = 1'b0;
  assign clr_ok = 1'b1;
  assign timeout_err = 1'b0;
`endif

  // next-state selection; done is ignored in the entry cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (run || step_pulse_q)
          state_d = FETCH;
      FETCH, DEC, RF, EXE, WB:
        if (!entry_q) begin
          if (cur_done)
            state_d = state_e'(state_q + 3'd1);
          else if (wd_hit)
            state_d = ERR;
        end
      RET:
        if (run && !halt_pend_q && !halt)
          state_d = FETCH;
        else
          state_d = IDLE;
      ERR:
        if (clr_ok)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // state register plus registered go/pc/busy/counter outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      go_q         <= '0;
      entry_q      <= 1'b0;
      step_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      halt_pend_q  <= 1'b0;
      br_q         <= 1'b0;
      pc_go_q      <= 1'b0;
      pc_br_q      <= 1'b0;
      busy_q       <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step;
      step_pulse_q <= ~step & step_q;
      entry_q      <= enter_stage;
      go_q         <= enter_stage ?
        (5'd1 << (state_d - 3'd1)) : 5'd0;
      busy_q       <= (state_d != IDLE);
      pc_go_q      <= (state_d == RET);
      pc_br_q      <= (state_d == RET) & br_q;
      if (state_q == EXE && !entry_q && dp.alu_done)
        br_q <= dp.branch_taken;
      if (state_q == RET ||
          (state_q == ERR && state_d == IDLE))
        halt_pend_q <= 1'b0;
      else if (halt && state_q != IDLE)
        halt_pend_q <= 1'b1;
      if (state_q == RET)
        retired_q <= retired_q + 1'b1;
    end
  end

  assign dp.fetch_go      = go_q[0];
  assign dp.dec_go        = go_q[1];
  assign dp.rf_go         = go_q[2];
  assign dp.alu_go        = go_q[3];
  assign dp.wb_go         = go_q[4];
  assign dp.pc_go         = pc_go_q;
  assign dp.pc_sel_branch = pc_br_q;
  assign busy             = busy_q;
  assign state            = state_q;
  assign retired          = retired_q;

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// tb_riscv_seq_ctrl: scoreboard bench for the sequencer; expected
// go/pc_go events are queued at stimulus time and popped on output.
module tb_riscv_seq_ctrl;

  typedef struct {
    int kind;
    int cyc;
    bit br;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step;
  logic        halt;
  logic        clr_err;
  logic        busy;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        timeout_err;

  riscv_seq_ctrl_if dp();

  riscv_seq_ctrl #(
    .TO_CYCLES(4),
    .CNT_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .step       (step),
    .halt       (halt),
    .clr_err    (clr_err),
    .dp         (dp),
    .busy       (busy),
    .state      (state),
    .retired    (retired),
    .timeout_err(timeout_err)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  ev_t  q[$];
  int   lat[5];
  int   cnt[5];
  logic [4:0] resp;
  logic stray_alu;
  int   inst_n = 0;
  int   br_at = -1;
  logic [5:0] mon_obs;
  ev_t  mon_e;

  assign dp.fetch_done   = resp[0];
  assign dp.dec_done     = resp[1];
  assign dp.rf_done      = resp[2];
  assign dp.alu_done     = resp[3] | stray_alu;
  assign dp.wb_done      = resp[4];
  assign dp.branch_taken = (inst_n == br_at);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // spec timing: next stage at t+k+1, RET after WB, pc_go in RET
  function automatic int push_instr(input int start, input bit br);
    int t;
    t = start;
    for (int i = 0; i < 5; i++) begin
      q.push_back('{kind: i, cyc: t, br: 1'b0});
      t = t + lat[i] + 1;
    end
    q.push_back('{kind: 5, cyc: t, br: br});
    return t;
  endfunction

  // datapath responder: done lat[i] cycles after go (0 = never)
  initial begin
    resp = '0;
    cnt = '{default: 0};
    forever begin
      tick();
      resp = '0;
      if (!rst_n) begin
        cnt = '{default: 0};
      end else begin
        if (dp.fetch_go) inst_n++;
        for (int i = 0; i < 5; i++) begin
          if ({dp.wb_go, dp.alu_go, dp.rf_go,
               dp.dec_go, dp.fetch_go}[i])
            cnt[i] = lat[i];
          else if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) resp[i] = 1'b1;
          end
        end
      end
    end
  end

  // scoreboard: every go / pc_go pulse must match the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      mon_obs = {dp.pc_go, dp.wb_go, dp.alu_go,
                 dp.rf_go, dp.dec_go, dp.fetch_go};
      for (int i = 0; i < 6; i++) begin
        if (mon_obs[i]) begin
          if (q.size() == 0) begin
            chk("sb_unexpected", i, 7);
          end else begin
            mon_e = q.pop_front();
            chk("sb_kind", i, mon_e.kind);
            chk("sb_cyc", cyc, mon_e.cyc);
            if (i == 5)
              chk("sb_br", dp.pc_sel_branch, mon_e.br);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int e, c, r, r1, r2, r3;
    rst_n = 1'b0;
    run = 1'b0;
    step = 1'b0;
    halt = 1'b0;
    clr_err = 1'b0;
    stray_alu = 1'b0;
    lat = '{1, 1, 1, 1, 1};
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_retired", retired, 0);
    chk("rst_fetch_go", dp.fetch_go, 0);
    chk("rst_pc_go", dp.pc_go, 0);
    chk("rst_pc_sel", dp.pc_sel_branch, 0);
    chk("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // single step, zero wait
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    e = cyc;
    r = push_instr(e + 2, 1'b0);
    chk("step_pc_at", r - e, 12);
    wait_until(r + 2);
    chk("step_state", state, 0);
    chk("step_busy", busy, 0);
    chk("step_retired", retired, 1);
    chk("step_drain", q.size(), 0);

    // run for three instructions, branch on the second
    br_at = inst_n + 2;
    run = 1'b1;
    c = cyc;
    r1 = push_instr(c + 1, 1'b0);
    r2 = push_instr(r1 + 1, 1'b1);
    r3 = push_instr(r2 + 1, 1'b0);
    wait_until(r2 + 3);
    run = 1'b0;
    wait_until(r3 + 2);
    chk("run_state", state, 0);
    chk("run_retired", retired, 4);
    chk("run_drain", q.size(), 0);

    // halt during EXE with run held high through RET
    run = 1'b1;
    c = cyc;
    r = push_instr(c + 1, 1'b0);
    wait_until(c + 8);
    chk("halt_in_exe", state, 4);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    wait_until(r);
    chk("halt_ret", state, 6);
    tick();
    chk("halt_idle", state, 0);
    run = 1'b0;
    wait_until(r + 4);
    chk("halt_state", state, 0);
    chk("halt_retired", retired, 5);
    chk("halt_drain", q.size(), 0);

    // wait states, stray alu_done, step while busy
    lat = '{2, 5, 1, 1, 1};
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    e = cyc;
    r = push_instr(e + 2, 1'b0);
    wait_until(e + 3);
    stray_alu = 1'b1;
    tick();
    stray_alu = 1'b0;
    step = 1'b1;
    wait_until(e + 6);
    step = 1'b0;
    wait_until(e + 10);
    chk("wait_dec_held", state, 2);
    tick();
    chk("wait_rf", state, 3);
    wait_until(r + 4);
    chk("wait_state", state, 0);
    chk("wait_retired", retired, 6);
    chk("wait_drain", q.size(), 0);
    lat = '{1, 1, 1, 1, 1};

    // async reset in WB with retired = 7
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    e = cyc;
    r = push_instr(e + 2, 1'b0);
    wait_until(r + 2);
    run = 1'b1;
    c = cyc;
    r = push_instr(c + 1, 1'b0);
    wait_until(c + 10);
    chk("pre_rst_state", state, 5);
    chk("pre_rst_retired", retired, 7);
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_retired", retired, 0);
    chk("arst_busy", busy, 0);
    chk("arst_go", {dp.fetch_go, dp.dec_go, dp.rf_go,
                    dp.alu_go, dp.wb_go}, 0);
    chk("arst_pc", {dp.pc_go, dp.pc_sel_branch}, 0);
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run = 1'b1;
    c = cyc;
    r = push_instr(c + 1, 1'b0);
    tick();
    tick();
    run = 1'b0;
    wait_until(r + 2);
    chk("restart_state", state, 0);
    chk("restart_retired", retired, 1);
    chk("restart_drain", q.size(), 0);

`ifdef RISCV_SEQ_TIMEOUT_EN
    // rf_done never arrives: ERR 5 cycles after rf_go
    lat[2] = 0;
    run = 1'b1;
    c = cyc;
    q.push_back('{kind: 0, cyc: c + 1, br: 1'b0});
    q.push_back('{kind: 1, cyc: c + 3, br: 1'b0});
    q.push_back('{kind: 2, cyc: c + 5, br: 1'b0});
    tick();
    run = 1'b0;
    wait_until(c + 9);
    chk("to_still_rf", state, 3);
    chk("to_no_err", timeout_err, 0);
    tick();
    chk("to_err_state", state, 7);
    chk("to_err_flag", timeout_err, 1);
    chk("to_err_busy", busy, 1);
    repeat (3) tick();
    chk("to_err_hold", state, 7);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("to_clr_state", state, 0);
    chk("to_clr_flag", timeout_err, 0);
    chk("to_drain", q.size(), 0);
    lat[2] = 1;
`else
    chk("to_tied", timeout_err, 0);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
